math_ip_axil_engine: RTL and testbench

Parametrised AXI4-Lite slave for the MATH_IP peripheral, the successor to the fixed four-register slave. It provides a configurable-width, configurable-depth register file with byte strobes and error responses. Writing CTRL drives a multi-cycle arithmetic engine with busy/done status and a level interrupt. It sits behind the PS/interconnect master port as the S00_AXI interface of MATH_IP.

---
 rtl/math_ip_axil_engine.sv | 112 +++++++++++
 tb/tb_math_ip_axil_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_ip_axil_engine.sv
// math_ip_axil_engine: AXI4-Lite register file slave driving a multi-cycle add/sub/mul engine.
module math_ip_axil_engine #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              IRQ
);
  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int SW = W / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int CW = $clog2(W);

  logic              rdy, aw_held, w_held, busy, done, err;
  logic [IW-1:0]     aw_idx, ar_idx;
  logic [W-1:0]      w_data, wr_val, rd_val, mplier, res_lo, res_hi;
  logic [SW-1:0]     w_strb;
  logic [W-1:0]      regs [NUM_REGS];
  logic [1:0]        op, wr_resp, rd_resp;
  logic [2*W-1:0]    acc, acc_n, mcand;
  logic [W:0]        addsub;
  logic [CW-1:0]     cnt;
  logic              commit, start, ar_bad, unused_ok;

  assign S_AXI_AWREADY = rdy & ~aw_held;
  assign S_AXI_WREADY  = rdy & ~w_held;
  assign S_AXI_ARREADY = rdy & ~S_AXI_RVALID;
  assign IRQ           = done & regs[2][3];
  assign ar_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_val = regs[aw_idx];
    for (int i = 0; i < SW; i++)
      if (w_strb[i]) wr_val[8*i+:8] = w_data[8*i+:8];
    wr_resp = 32'(aw_idx) >= NUM_REGS ? 2'b11 :
              (aw_idx >= IW'(3) && aw_idx <= IW'(5)) || (aw_idx < IW'(3) && busy) ? 2'b10 : 2'b00;
    commit  = aw_held & w_held & ~S_AXI_BVALID;
    start   = commit & (aw_idx == IW'(2)) & (wr_resp == 2'b00) & wr_val[0];
    ar_bad  = 32'(ar_idx) >= NUM_REGS;
    rd_resp = ar_bad ? 2'b11 : 2'b00;
    rd_val  = ar_bad ? '0 :
              ar_idx == IW'(3) ? {{(W-3){1'b0}}, err, done, busy} :
              ar_idx == IW'(4) ? res_lo :
              ar_idx == IW'(5) ? res_hi : regs[ar_idx];
    addsub  = op[0] ? {1'b0, mcand[W-1:0]} - {1'b0, mplier} : {1'b0, mcand[W-1:0]} + {1'b0, mplier};
    acc_n   = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy <= 1'b0; aw_held <= 1'b0; w_held <= 1'b0; aw_idx <= '0; w_data <= '0; w_strb <= '0;
      S_AXI_BVALID <= 1'b0; S_AXI_BRESP <= '0; S_AXI_RVALID <= 1'b0; S_AXI_RDATA <= '0; S_AXI_RRESP <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; op <= '0; acc <= '0; mcand <= '0; mplier <= '0;
      cnt <= '0; res_lo <= '0; res_hi <= '0;
    end else begin
      rdy <= 1'b1;
      aw_held <= commit ? 1'b0 : aw_held | (S_AXI_AWREADY & S_AXI_AWVALID);
      w_held  <= commit ? 1'b0 : w_held | (S_AXI_WREADY & S_AXI_WVALID);
      if (S_AXI_AWREADY & S_AXI_AWVALID) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (S_AXI_WREADY & S_AXI_WVALID) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_resp;
        // CTRL keeps only OP and IE; START is a pulse and never stored
        if (wr_resp == 2'b00) regs[aw_idx] <= aw_idx == IW'(2) ? wr_val & W'(14) : wr_val;
      end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (S_AXI_ARREADY & S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (start) begin
        busy <= 1'b1; done <= 1'b0; err <= 1'b0; op <= wr_val[2:1];
        acc <= '0; mcand <= {{W{1'b0}}, regs[0]}; mplier <= regs[1]; cnt <= CW'(W-1);
      end else if (busy && op == 2'd2) begin
        acc <= acc_n; mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          busy <= 1'b0; done <= 1'b1; {res_hi, res_lo} <= acc_n;
        end
      end else if (busy) begin
        busy <= 1'b0; done <= 1'b1; err <= op == 2'd3;
        if (op != 2'd3) {res_hi, res_lo} <= {{(W-1){1'b0}}, addsub};
      end
    end
  end
endmodule

// File: tb/tb_math_ip_axil_engine.sv
// tb_math_ip_axil_engine: directed table-driven bench for the AXI4-Lite math engine.
module tb_math_ip_axil_engine;
  logic        clk = 0, rst_n = 0;
  logic [5:0]  awaddr = 0, araddr = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic        arvalid = 0, arready, rvalid, rready = 1, irq;
  logic [31:0] wdata = 0, rdata;
  logic [3:0]  wstrb = 0;
  logic [1:0]  bresp, rresp;
  int          n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[$];

  math_ip_axil_engine #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(8), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .IRQ(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(bit w, logic [5:0] a, logic [31:0] d, logic [3:0] s, logic [1:0] r, logic [31:0] e);
    vec_t t;
    t.wr = w; t.a = a; t.d = d; t.s = s; t.resp = r; t.exp = e;
    return t;
  endfunction

  // c returns the cycle number of the commit edge (the edge on which BVALID rose)
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r, output int c);
    bit ad = 0, wd = 0, got = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; r = 2'bxx; c = 0;
    for (int i = 0; i < 50 && !(ad && wd); i++) begin
      @(negedge clk);
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(posedge clk); #1;
      if (ad) awvalid = 0;
      if (wd) wvalid = 0;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bvalid) begin got = 1; r = bresp; c = cyc; end
      @(posedge clk); #1;
    end
    chk("wr_handshake_done", {ad, wd, got}, 3'b111);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    bit hs = 0, got = 0;
    araddr = a; arvalid = 1; d = 'x; r = 'x;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (arready) hs = 1;
      @(posedge clk); #1;
      if (hs) arvalid = 0;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rvalid) begin got = 1; d = rdata; r = rresp; end
      @(posedge clk); #1;
    end
    chk("rd_handshake_done", {hs, got}, 2'b11);
  endtask

  task automatic rchk(input string nm, input logic [5:0] a, input logic [31:0] e);
    logic [31:0] d;
    logic [1:0]  r;
    rd(a, d, r);
    chk({nm, "_rdata"}, d, e);
    chk({nm, "_rresp"}, r, 2'b00);
  endtask

  task automatic wait_irq(output int c);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (irq) got = 1;
    end
    c = cyc;
    chk("irq_within_bound", got, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          c0, c1, cs;

    tv.push_back(v(1, 6'h18, 32'h1,        4'hF, 2'b00, 0));
    tv.push_back(v(1, 6'h1C, 32'h2,        4'hF, 2'b00, 0));
    tv.push_back(v(1, 6'h00, 32'h3,        4'hF, 2'b00, 0));
    tv.push_back(v(1, 6'h04, 32'h4,        4'hF, 2'b00, 0));
    tv.push_back(v(0, 6'h18, 0, 0, 2'b00, 32'h1));
    tv.push_back(v(0, 6'h1C, 0, 0, 2'b00, 32'h2));
    tv.push_back(v(0, 6'h00, 0, 0, 2'b00, 32'h3));
    tv.push_back(v(0, 6'h04, 0, 0, 2'b00, 32'h4));
    tv.push_back(v(1, 6'h18, 32'h11223344, 4'hF, 2'b00, 0));
    tv.push_back(v(1, 6'h18, 32'hAABBCCDD, 4'h5, 2'b00, 0));
    tv.push_back(v(0, 6'h1B, 0, 0, 2'b00, 32'h11BB33DD));
    tv.push_back(v(1, 6'h10, 32'h5,        4'hF, 2'b10, 0));
    tv.push_back(v(1, 6'h0C, 32'h5,        4'hF, 2'b10, 0));
    tv.push_back(v(1, 6'h14, 32'h5,        4'hF, 2'b10, 0));
    tv.push_back(v(0, 6'h10, 0, 0, 2'b00, 32'h0));
    tv.push_back(v(0, 6'h0C, 0, 0, 2'b00, 32'h0));
    tv.push_back(v(1, 6'h20, 32'h9,        4'hF, 2'b11, 0));
    tv.push_back(v(0, 6'h20, 0, 0, 2'b11, 32'h0));
    tv.push_back(v(0, 6'h3C, 0, 0, 2'b11, 32'h0));
    tv.push_back(v(1, 6'h08, 32'hE,        4'hF, 2'b00, 0));
    tv.push_back(v(0, 6'h08, 0, 0, 2'b00, 32'hE));
    tv.push_back(v(1, 6'h08, 32'h0,        4'hF, 2'b00, 0));
    tv.push_back(v(0, 6'h08, 0, 0, 2'b00, 32'h0));

    #2;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata_resp", {rdata, rresp, bresp}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk) chk("rel_awready_early", awready, 0);
    @(negedge clk) chk("rel_awready", awready, 1);
    chk("rel_wready_arready", {wready, arready}, 2'b11);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      if (tv[i].wr) begin
        wr(tv[i].a, tv[i].d, tv[i].s, r, c0);
        chk($sformatf("vec%0d_bresp", i), r, tv[i].resp);
      end else begin
        rd(tv[i].a, d, r);
        chk($sformatf("vec%0d_rresp", i), r, tv[i].resp);
        chk($sformatf("vec%0d_rdata", i), d, tv[i].exp);
      end
    end

    // W arrives 3 cycles ahead of AW while BREADY is held low
    bready = 0; wvalid = 1; wdata = 32'hCAFE0001; wstrb = 4'hF;
    @(negedge clk) chk("early_w_wready", wready, 1);
    @(posedge clk); #1 wvalid = 0;
    repeat (2) @(posedge clk);
    #1 awvalid = 1; awaddr = 6'h18;
    @(negedge clk) chk("late_aw_awready", awready, 1);
    @(posedge clk); #1 awvalid = 0;
    @(posedge clk); #1 awvalid = 1; awaddr = 6'h1C; wvalid = 1; wdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bhold%0d_bvalid", i), bvalid, 1);
      chk($sformatf("bhold%0d_bresp", i), bresp, 2'b00);
      if (i > 0) chk($sformatf("bhold%0d_awready", i), awready, 0);
      @(posedge clk); #1;
      if (i == 0) begin awvalid = 0; wvalid = 0; end
    end
    bready = 1;
    @(negedge clk) chk("bhold_last_bvalid", bvalid, 1);
    @(negedge clk) chk("b_accepted_bvalid", bvalid, 0);
    chk("b_accepted_awready", awready, 0);
    @(negedge clk) chk("second_commit_bvalid", bvalid, 1);
    @(posedge clk); #1;
    rchk("stall_reg6", 6'h18, 32'hCAFE0001);
    rchk("stall_reg7", 6'h1C, 32'h55);

    // add with carry out, IE set
    wr(6'h00, 32'hFFFFFFFF, 4'hF, r, c0);
    wr(6'h04, 32'h1, 4'hF, r, c0);
    wr(6'h08, 32'h9, 4'hF, r, c0);
    chk("add_start_bresp", r, 2'b00);
    wait_irq(c1);
    chk("add_latency", c1 - c0, 1);
    rchk("add_lo", 6'h10, 32'h0);
    rchk("add_hi", 6'h14, 32'h1);
    rchk("add_status", 6'h0C, 32'h2);
    rchk("ctrl_start_reads0", 6'h08, 32'h8);

    // sub with borrow
    wr(6'h00, 32'h0, 4'hF, r, c0);
    wr(6'h04, 32'h1, 4'hF, r, c0);
    wr(6'h08, 32'hB, 4'hF, r, c0);
    wait_irq(c1);
    chk("sub_latency", c1 - c0, 1);
    rchk("sub_lo", 6'h10, 32'hFFFFFFFF);
    rchk("sub_hi", 6'h14, 32'h1);

    // full-scale mul with a blocked operand write while busy
    wr(6'h00, 32'hFFFFFFFF, 4'hF, r, c0);
    wr(6'h04, 32'hFFFFFFFF, 4'hF, r, c0);
    wr(6'h08, 32'hD, 4'hF, r, cs);
    chk("mul_irq_cleared", irq, 0);
    rchk("mul_busy", 6'h0C, 32'h1);
    wr(6'h00, 32'h1234, 4'hF, r, c0);
    chk("busy_opa_slverr", r, 2'b10);
    rchk("busy_opa_kept", 6'h00, 32'hFFFFFFFF);
    wait_irq(c1);
    chk("mul_latency", c1 - cs, 32);
    rchk("mul_lo", 6'h10, 32'h00000001);
    rchk("mul_hi", 6'h14, 32'hFFFFFFFE);
    rchk("mul_status", 6'h0C, 32'h2);

    // reserved op: ERR and DONE, results untouched
    wr(6'h08, 32'hF, 4'hF, r, c0);
    wait_irq(c1);
    chk("err_latency", c1 - c0, 1);
    rchk("err_status", 6'h0C, 32'h6);
    rchk("err_lo_kept", 6'h10, 32'h00000001);
    rchk("err_hi_kept", 6'h14, 32'hFFFFFFFE);
    wr(6'h08, 32'h0, 4'hF, r, c0);
    @(negedge clk) chk("irq_ie_off", irq, 0);
    @(posedge clk); #1;

    // small muls exercising the shift path
    wr(6'h00, 32'h10000, 4'hF, r, c0);
    wr(6'h04, 32'h10000, 4'hF, r, c0);
    wr(6'h08, 32'hD, 4'hF, r, cs);
    wait_irq(c1);
    rchk("mul2_lo", 6'h10, 32'h0);
    rchk("mul2_hi", 6'h14, 32'h1);
    wr(6'h00, 32'h7, 4'hF, r, c0);
    wr(6'h04, 32'h6, 4'hF, r, c0);
    wr(6'h08, 32'hD, 4'hF, r, cs);
    wait_irq(c1);
    rchk("mul3_lo", 6'h10, 32'h2A);
    rchk("mul3_hi", 6'h14, 32'h0);

    // reset mid-mul with B and R both outstanding
    wr(6'h00, 32'hFFFFFFFF, 4'hF, r, c0);
    wr(6'h04, 32'hFFFFFFFF, 4'hF, r, c0);
    wr(6'h08, 32'hD, 4'hF, r, cs);
    bready = 0; rready = 0;
    awaddr = 6'h18; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(posedge clk); #1 araddr = 6'h0C; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk);
    chk("pre_rst_bvalid", bvalid, 1);
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_busy", rdata, 32'h1);
    rst_n = 0;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
    chk("mid_rst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1; bready = 1; rready = 1;
    @(negedge clk) chk("rerel_awready_early", awready, 0);
    @(negedge clk) chk("rerel_awready", awready, 1);
    @(posedge clk); #1;
    rchk("post_rst_opa", 6'h00, 32'h0);
    rchk("post_rst_opb", 6'h04, 32'h0);
    rchk("post_rst_ctrl", 6'h08, 32'h0);
    rchk("post_rst_status", 6'h0C, 32'h0);
    rchk("post_rst_lo", 6'h10, 32'h0);
    rchk("post_rst_hi", 6'h14, 32'h0);
    rchk("post_rst_scratch", 6'h18, 32'h0);
    chk("post_rst_irq", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
